upsampler_48_96: RTL and testbench



---
 rtl/upsampler_48_96_pkg.sv | 27 ++
 rtl/upsampler_48_96_if.sv | 25 ++
 rtl/upsampler_48_96_hist.sv | 32 +++
 rtl/upsampler_48_96.sv | 126 ++++++++++++
 tb/tb_upsampler_48_96.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/upsampler_48_96_pkg.sv
// Shared definitions for the 48->96 kHz mixer path: sample widths,
// upsampler FSM states and the 24-bit saturation helper.
package dmix_pkg;

  localparam int SAMPLE_W = 24;
  localparam int COEFF_W  = 24;
  localparam int ROM_AW   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC0,
    ST_OUT0,
    ST_MAC1,
    ST_OUT1
  } upsampler_state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat24(input logic signed [63:0] v);
    if (v > 64'sd8388607) begin
      return 24'sh7FFFFF;
    end else if (v < -64'sd8388608) begin
      return 24'sh800000;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/upsampler_48_96_if.sv
// Sample-in, sample-out and coefficient ROM signals of the 2x upsampler,
// named from the upsampler's point of view.
interface upsampler_48_96_if;
  import dmix_pkg::*;

  logic                       valid_i;
  logic                       ready_o;
  logic signed [SAMPLE_W-1:0] data_i;
  logic                       valid_o;
  logic                       ready_i;
  logic signed [SAMPLE_W-1:0] data_o;
  logic [ROM_AW-1:0]          rom_addr_o;
  logic signed [COEFF_W-1:0]  rom_data_i;

  modport slave (
    input  valid_i, data_i, ready_i, rom_data_i,
    output ready_o, valid_o, data_o, rom_addr_o
  );

  modport master (
    output valid_i, data_i, ready_i, rom_data_i,
    input  ready_o, valid_o, data_o, rom_addr_o
  );

endinterface

// File: rtl/upsampler_48_96_hist.sv
// 16-entry sample history ring: writes advance the pointer, reads are
// indexed by tap distance back from the most recently written sample.
module fir_hist_ring16
  import dmix_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic signed [SAMPLE_W-1:0] wr_data_i,
  input  logic [3:0]                 tap_i,
  output logic signed [SAMPLE_W-1:0] rd_data_o
);

  logic signed [SAMPLE_W-1:0] mem_q [16];
  logic [3:0]                 wp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wp_q] <= wr_data_i;
      wp_q        <= wp_q + 4'd1;
    end
  end

  // wp_q already points past the newest sample, hence the extra -1
  assign rd_data_o = mem_q[wp_q - 4'd1 - tap_i];

endmodule

// File: rtl/upsampler_48_96.sv
// Polyphase 2x interpolator: each accepted 48 kHz sample yields a phase-0
// and a phase-1 16-tap dot product against the external coefficient ROM.
module upsampler_48_96
  import dmix_pkg::*;
#(
  parameter int TAPS        = 16,
  parameter int COEFF_SHIFT = 23,
  parameter int ACC_W       = 52
) (
  input logic               clk,
  input logic               rst_n,
  upsampler_48_96_if.slave  bus
);

  localparam int         PW = SAMPLE_W + COEFF_W;
  localparam logic [4:0] T5 = 5'(TAPS);

  upsampler_state_t           state_q, state_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [ROM_AW-1:0]          addr_q, addr_d;
  logic signed [SAMPLE_W-1:0] x_q, x_d, data_q, data_d, hist_rd;
  logic signed [PW-1:0]       prod_q, prod_d, coeff_ext, x_ext;
  logic signed [ACC_W-1:0]    acc_q, acc_d, prod_acc, acc_sh;
  logic signed [63:0]         acc_sh_ext;
  logic                       valid_q, valid_d, ready_q, ready_d, wr_en;

  fir_hist_ring16 u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (bus.data_i),
    .tap_i     (cnt_q[3:0] - 4'd1),
    .rd_data_o (hist_rd)
  );

  assign coeff_ext  = {{(PW-COEFF_W){bus.rom_data_i[COEFF_W-1]}}, bus.rom_data_i};
  assign x_ext      = {{(PW-SAMPLE_W){x_q[SAMPLE_W-1]}}, x_q};
  assign prod_acc   = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
  assign acc_sh     = acc_q >>> COEFF_SHIFT;
  assign acc_sh_ext = {{(64-ACC_W){acc_sh[ACC_W-1]}}, acc_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // MAC pipeline keyed on cnt_q: address issue, ROM/history capture,
  // multiply, accumulate, then the saturated result three cycles after the last issue
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    x_d     = x_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.valid_i && ready_q) begin
          wr_en   = 1'b1;
          state_d = ST_MAC0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_MAC0, ST_MAC1: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q < T5) begin
          addr_d = {(state_q == ST_MAC1), cnt_q[3:0]};
        end
        if (cnt_q >= 5'd1 && cnt_q <= T5) begin
          x_d = hist_rd;
        end
        if (cnt_q >= 5'd2 && cnt_q <= T5 + 5'd1) begin
          prod_d = coeff_ext * x_ext;
        end
        if (cnt_q >= 5'd3 && cnt_q <= T5 + 5'd2) begin
          acc_d = acc_q + prod_acc;
        end
        if (cnt_q == T5 + 5'd3) begin
          data_d  = sat24(acc_sh_ext);
          valid_d = 1'b1;
          state_d = (state_q == ST_MAC0) ? ST_OUT0 : ST_OUT1;
        end
      end
      ST_OUT0, ST_OUT1: begin
        if (bus.ready_i) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (state_q == ST_OUT0) ? ST_MAC1 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_d = (state_d == ST_IDLE);

  assign bus.ready_o    = ready_q;
  assign bus.valid_o    = valid_q;
  assign bus.data_o     = data_q;
  assign bus.rom_addr_o = addr_q;

endmodule

// File: tb/tb_upsampler_48_96.sv
// Directed bench for upsampler_48_96: impulse, latency, back-pressure,
// ramp against a 16-tap golden model, mid-frame reset, and saturation.
module tb_upsampler_48_96;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  upsampler_48_96_if busA ();
  upsampler_48_96_if busB ();

  upsampler_48_96 dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  upsampler_48_96 #(.COEFF_SHIFT(20)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  logic               useB;
  logic               vIn;
  logic               rdyIn;
  logic signed [23:0] dIn;
  logic signed [23:0] rom [32];
  longint             modelHist [16];
  int                 vectors = 0;
  int                 miscompares = 0;

  assign busA.valid_i = vIn & ~useB;
  assign busB.valid_i = vIn & useB;
  assign busA.data_i  = dIn;
  assign busB.data_i  = dIn;
  assign busA.ready_i = rdyIn;
  assign busB.ready_i = rdyIn;

  always @(posedge clk) busA.rom_data_i <= rom[busA.rom_addr_o];
  always @(posedge clk) busB.rom_data_i <= rom[busB.rom_addr_o];

  logic               obsValid, obsReady;
  logic signed [23:0] obsData;
  assign obsValid = useB ? busB.valid_o : busA.valid_o;
  assign obsReady = useB ? busB.ready_o : busA.ready_o;
  assign obsData  = useB ? busB.data_o  : busA.data_o;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic signed [23:0] sample);
    int n = 0;
    @(negedge clk);
    while (obsReady !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (obsReady !== 1'b1) checkOutput("accept_timeout", obsReady, 1);
    vIn = 1'b1;
    dIn = sample;
    @(posedge clk);
    #1 vIn = 1'b0;
  endtask

  task automatic waitOutput(input string tag, input logic signed [63:0] expected);
    int n = 0;
    while (obsValid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (obsValid !== 1'b1) checkOutput({tag, "_timeout"}, obsValid, 1);
    else checkOutput(tag, obsData, expected);
    if (rdyIn) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runFrame(input logic signed [23:0] sample, input logic signed [63:0] e0,
                          input logic signed [63:0] e1, input string tag);
    applyStimulus(sample);
    waitOutput({tag, "_p0"}, e0);
    waitOutput({tag, "_p1"}, e1);
  endtask

  task automatic modelPush(input longint x);
    for (int k = 15; k > 0; k--) modelHist[k] = modelHist[k-1];
    modelHist[0] = x;
  endtask

  task automatic modelClear();
    for (int k = 0; k < 16; k++) modelHist[k] = 0;
  endtask

  // Straight dot product over the model's shift-register history
  function automatic longint golden(input int p);
    longint s = 0;
    for (int k = 0; k < 16; k++) s += longint'(rom[p*16+k]) * modelHist[k];
    s = s >>> 23;
    if (s > 8388607) s = 8388607;
    if (s < -8388608) s = -8388608;
    return s;
  endfunction

  initial begin
    logic signed [63:0] exp0, exp1;
    int bpBad;

    for (int i = 0; i < 32; i++) rom[i] = 24'(i * 524287 - 8000000);
    rom[0]  = 24'sd2922076;
    rom[1]  = -24'sd1346097;
    rom[16] = 24'sd7032135;
    rom[17] = -24'sd911323;
    modelClear();
    useB = 1'b0; vIn = 1'b0; dIn = '0; rdyIn = 1'b1; rst_n = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", busA.ready_o, 1);
    checkOutput("rst_valid", busA.valid_o, 0);
    checkOutput("rst_data", busA.data_o, 0);
    checkOutput("rst_addr", busA.rom_addr_o, 0);
    rst_n = 1'b1;

    // Impulse frame with cycle-exact latency and address-order checks
    modelPush(1048576);
    applyStimulus(24'sd1048576);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("lat_addr_p0_%0d", i), busA.rom_addr_o, i);
    end
    repeat (3) @(posedge clk);
    #1 checkOutput("lat_valid_E19", obsValid, 0);
    @(posedge clk); #1;
    checkOutput("lat_valid_E20", obsValid, 1);
    checkOutput("imp0_p0", obsData, 365259);
    checkOutput("busy_ready", obsReady, 0);
    @(posedge clk); #1;
    checkOutput("hs_valid_clear", obsValid, 0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("lat_addr_p1_%0d", i), busA.rom_addr_o, 16 + i);
    end
    repeat (3) @(posedge clk);
    #1 checkOutput("lat_valid_H19", obsValid, 0);
    @(posedge clk); #1;
    checkOutput("lat_valid_H20", obsValid, 1);
    checkOutput("imp0_p1", obsData, 879016);
    checkOutput("busy_ready_p1", obsReady, 0);
    @(posedge clk); #1;
    checkOutput("ready_after_hs", obsReady, 1);

    modelPush(0);
    runFrame(24'sd0, -168263, -113916, "imp1");
    for (int k = 2; k < 16; k++) begin
      modelPush(0);
      runFrame(24'sd0, rom[k] >>> 3, rom[16+k] >>> 3, $sformatf("imp%0d", k));
    end
    modelPush(0);
    runFrame(24'sd0, 0, 0, "imp_tail");

    for (int i = 1; i <= 40; i++) begin
      modelPush(i);
      runFrame(24'(i), golden(0), golden(1), $sformatf("ramp%0d", i));
    end

    // Hold phase 0 for 100 cycles while a stray valid_i is offered
    rdyIn = 1'b0;
    modelPush(4000000);
    exp0 = golden(0);
    exp1 = golden(1);
    applyStimulus(24'sd4000000);
    waitOutput("bp_p0", exp0);
    bpBad = 0;
    vIn = 1'b1;
    dIn = -24'sd5;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (obsValid !== 1'b1 || obsData !== exp0 || obsReady !== 1'b0) bpBad++;
    end
    vIn = 1'b0;
    checkOutput("bp_hold_bad_cycles", bpBad, 0);
    rdyIn = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_clear", obsValid, 0);
    waitOutput("bp_p1", exp1);
    modelPush(0);
    runFrame(24'sd0, golden(0), golden(1), "bp_after");

    // Reset in the middle of phase-1 accumulation
    modelPush(2000000);
    applyStimulus(24'sd2000000);
    waitOutput("rstmid_p0", golden(0));
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_valid", obsValid, 0);
    checkOutput("rstmid_ready", obsReady, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("rstmid_no_output", obsValid, 0);
    checkOutput("rstmid_ready_after", obsReady, 1);
    modelClear();
    runFrame(24'sd1048576, 365259, 879016, "rimp0");
    runFrame(24'sd0, -168263, -113916, "rimp1");
    runFrame(24'sd0, rom[2] >>> 3, rom[18] >>> 3, "rimp2");

    // Saturation on the COEFF_SHIFT=20 instance
    useB = 1'b1;
    runFrame(24'sd8388607, 8388607, 8388607, "sat_pos");
    runFrame(-24'sd8388608, -8388608, -8388608, "sat_neg");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
